aes_inv_keyexpansion_128: RTL
=============================

# aes_inv_keyexpansion_128

AES-128 inverse key schedule that walks the key expansion backwards for decryption. From the round-10 key it produces round keys 10, 9, …, 0 in order, one per accepted advance, so the decryption datapath gets keys in the order it consumes them. It sits beside the forward key-expansion block in the key expansion and memory subsystem. It removes the need to store all eleven round keys before decrypting.

## Interface
No parameters (AES-128 only).
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; highest priority
- start  input  1  one-cycle pulse; samples last_key and starts a walk
- last_key  input  128  round-10 key; word 0 in [127:96], word 3 in [31:0]
- advance  input  1  consumer has used the current subkey; step to the previous round
- subkey  output  128  registered round key for round cnt128; same word order as last_key
- cnt128  output  4  round index of subkey, 10 down to 0
- valid_skey  output  1  subkey/cnt128 valid; high for the whole walk

## Operation
- State: key register K[127:0], round register R[3:0], status bit V. Outputs are driven directly from the registers: subkey=K, cnt128=R, valid_skey=V.
- Priority each cycle is reset > start > advance.
  - reset: K=0, R=0, V=0.
  - start: K=last_key, R=10, V=1. start restarts any walk in progress and discards the old key.
  - advance with V=1 and R≥1: K=inv(K, R), R=R−1, V stays 1.
  - advance with V=1 and R=0: K=0, R=0, V=0 (walk done).
  - advance with V=0: ignored, no state change.
  - No advance and no start: hold all state.
- inv(K, r): take K words k0..k3 (k0=[127:96]) as round-r key words w[4r..4r+3]. The previous round-key words p0..p3 are:
  - p3 = k3 ^ k2
  - p2 = k2 ^ k1
  - p1 = k1 ^ k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r], 24'h0}
- RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the forward AES S-box to each byte; forward, not inverse. The S-box may be table-based or composite-field, but must be purely combinational.
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1B,36. Rcon for r=0 is don't-care because it is never used.
- All XOR is bitwise GF(2), with no width growth.

## Timing
- Reset values: subkey=0, cnt128=0, valid_skey=0.
- Start latency: if start is high in cycle T, then in cycle T+1 valid_skey=1, cnt128=10 and subkey=last_key.
- Step latency: an advance in cycle T updates subkey and cnt128 in T+1. There is one combinational inverse step per cycle.
- Maximum rate is one key per cycle (advance held high): rounds 10..0 appear in cycles T+1..T+11, and valid_skey drops in T+12.
- Holding advance low holds subkey stable indefinitely, with no timeout.
- start and advance in the same cycle: start wins, and the walk reloads at round 10.
- Reset mid-walk clears everything in the next cycle. A later start begins cleanly.
- After the walk, subkey=0 and cnt128=0 with valid_skey=0. The consumer must use round-0 data only while valid_skey=1.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and advance held high.
  - Required: cnt128 runs 10→0 in consecutive cycles.
  - Round 9 subkey = ac7766f319fadc2128d12941575c006e.
  - Round 1 subkey = a0fafe1788542cb123a339392a6c7605.
  - Round 0 subkey = 2b7e151628aed2a6abf7158809cf4f3c.
  - valid_skey falls one cycle after round 0.
- Same key, advance toggled randomly: the sequence of subkey values is identical to the back-to-back run, and subkey is stable on every cycle with advance=0.
- start pulse at cnt128=5 with a new last_key (round-10 key of the all-zero cipher key, b4ef5bcb3e92e21123e951cf6f8f188e): next cycle cnt128=10 and subkey equals the new key; the walk ends at round 0 = all zeros.
- reset asserted at cnt128=7 together with start and advance: next cycle all outputs are 0; a start two cycles later behaves as in the first test.
- advance pulses with valid_skey=0, before any start and after a walk completes: outputs remain 0.
- Scoreboard cross-check: for 100 random cipher keys, run the forward key expansion block, feed its round-10 key here, and compare all 11 round keys in reverse order.

Source files
------------

// File: rtl/aes_inv_keyexpansion_128.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : aes_inv_keyexpansion_128                                        |
// | Desc   : AES-128 inverse key schedule, emits round keys 10 down to 0.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module aes_inv_keyexpansion_128 (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] last_key_i,
  input  logic         advance_i,
  output logic [127:0] subkey_o,
  output logic [3:0]   cnt128_o,
  output logic         valid_skey_o
);

  localparam logic [0:255][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return C_SBOX[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         vld_q, vld_d;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_p0, w_p1, w_p2, w_p3;
  logic [31:0]  w_rot, w_sub;

  assign w_k0 = key_q[127:96];
  assign w_k1 = key_q[95:64];
  assign w_k2 = key_q[63:32];
  assign w_k3 = key_q[31:0];

  // Later words of the forward schedule are XOR chains, so they unwind directly.
  assign w_p3  = w_k3 ^ w_k2;
  assign w_p2  = w_k2 ^ w_k1;
  assign w_p1  = w_k1 ^ w_k0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_p0  = w_k0 ^ w_sub ^ {rcon(rnd_q), 24'h000000};

  always_comb begin
    key_d = key_q;
    rnd_d = rnd_q;
    vld_d = vld_q;
    if (start_i) begin
      key_d = last_key_i;
      rnd_d = 4'd10;
      vld_d = 1'b1;
    end else if (advance_i && vld_q) begin
      if (rnd_q != 4'd0) begin
        key_d = {w_p0, w_p1, w_p2, w_p3};
        rnd_d = rnd_q - 4'd1;
      end else begin
        key_d = '0;
        rnd_d = 4'd0;
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_q <= '0;
      rnd_q <= 4'd0;
      vld_q <= 1'b0;
    end else begin
      key_q <= key_d;
      rnd_q <= rnd_d;
      vld_q <= vld_d;
    end
  end

  assign subkey_o     = key_q;
  assign cnt128_o     = rnd_q;
  assign valid_skey_o = vld_q;

endmodule
`default_nettype wire
